// File: rtl/ft245_pkg.sv
// ---------------------------------------------------------------------------
// ft245_pkg
// Shared definitions for the FT245 FIFO interface (read and write paths).
//   - strobe FSM state encoding
//   - data bus width
//   - default strobe timing and buffer depth
//   - cnt_width(): width of a down-counter able to hold the longer phase
// No ports (package).
// ---------------------------------------------------------------------------
package ft245_pkg;

  localparam int D_WIDTH = 8;

  typedef logic [D_WIDTH-1:0] ft245_byte_t;

  // Strobe FSM states, kept as plain constants so legacy code can compare
  // against raw 2-bit values.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RD_LOW  = 2'b01;
  localparam logic [1:0] ST_RD_HIGH = 2'b10;

  localparam int FIFO_DEPTH_DEF     = 16;
  localparam int RD_LOW_CYCLES_DEF  = 3;
  localparam int RD_HIGH_CYCLES_DEF = 4;

  // The counter is loaded with (phase length - 1), so $clog2 of the longest
  // phase is enough; a single-cycle phase still needs one bit.
  function automatic int cnt_width(input int low_cycles, input int high_cycles);
    int longest;
    longest = (low_cycles > high_cycles) ? low_cycles : high_cycles;
    return (longest < 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/ft245_rx_fifo.sv
// ---------------------------------------------------------------------------
// ft245_rx_fifo
// Synchronous first-word-fall-through FIFO buffering received bytes.
// Parameters: DEPTH (power of 2, >= 2), WIDTH (entry width).
// Ports:
//   clock_in    in   clock, posedge
//   reset_n     in   asynchronous active-low reset (empties the FIFO)
//   push        in   write push_data this edge
//   push_data   in   WIDTH-bit entry to store
//   pop         in   discard head entry this edge
//   head_data   out  head entry (0 while empty)
//   head_valid  out  FIFO not empty
//   level       out  occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ft245_rx_fifo
  import ft245_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = D_WIDTH
) (
  input  logic                   clock_in,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only accepted when a pop frees the slot in
  // the same cycle; the level therefore can never exceed DEPTH.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != LVL_W'(DEPTH)) || do_pop);

  always_ff @(posedge clock_in) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The memory has no reset, so the head is masked while empty.
  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;
  assign level      = count;

endmodule

// File: rtl/ft245_fifo_read.sv
// ---------------------------------------------------------------------------
// ft245_fifo_read
// Receive path of the FT245 asynchronous FIFO interface. Strobes rd_n while
// the device reports data (rxf_n low), buffers each byte in ft245_rx_fifo and
// presents it on a valid/ready stream.
// Parameters: DEPTH (power of 2, >= 2), RD_LOW_CYCLES (>= 1),
//             RD_HIGH_CYCLES (>= 3, covers the rxf_n synchronizer).
// Ports:
//   clock_in    in   system clock, posedge
//   reset_n     in   asynchronous active-low reset
//   rxf_n       in   FT245 receive flag, asynchronous, low = byte available
//   data_in     in   FT245 data bus (stable while rd_n is low)
//   rd_n        out  FT245 read strobe, active low, registered
//   enable      in   permits new read strobes
//   m_data      out  head-of-FIFO byte
//   m_valid     out  m_data valid
//   m_ready     in   downstream accepts (pop on m_valid && m_ready)
//   fifo_level  out  FIFO occupancy
//   receive_on  out  high while a strobe sequence is in progress
//   rx_count    out  32-bit count of pushed bytes, wraps
//                    (present only with FT245_RX_BYTE_COUNT_EN defined)
// ---------------------------------------------------------------------------
module ft245_fifo_read
  import ft245_pkg::*;
#(
  parameter int DEPTH          = FIFO_DEPTH_DEF,
  parameter int RD_LOW_CYCLES  = RD_LOW_CYCLES_DEF,
  parameter int RD_HIGH_CYCLES = RD_HIGH_CYCLES_DEF
) (
  input  logic                   clock_in,
  input  logic                   reset_n,
  input  logic                   rxf_n,
  input  logic [D_WIDTH-1:0]     data_in,
  output logic                   rd_n,
  input  logic                   enable,
  output logic [D_WIDTH-1:0]     m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   receive_on
`ifdef FT245_RX_BYTE_COUNT_EN
  ,
  output logic [31:0]            rx_count
`endif
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = cnt_width(RD_LOW_CYCLES, RD_HIGH_CYCLES);

  logic             rxf_meta;
  logic             rxf_s;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;

  // Two-flop synchronizer; resets to "no data" so nothing is read until the
  // flag has been seen low for two full edges.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      rxf_meta <= 1'b1;
      rxf_s    <= 1'b1;
    end else begin
      rxf_meta <= rxf_n;
      rxf_s    <= rxf_meta;
    end
  end

  // Strobe sequencer. Room in the FIFO is checked only when a strobe starts:
  // pops during the strobe can only add room, so the push at the end of
  // RD_LOW always fits. Once started, a strobe runs to completion regardless
  // of enable or rxf_n.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rd_n  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && !rxf_s && (fifo_level < LVL_W'(DEPTH))) begin
            state <= ST_RD_LOW;
            rd_n  <= 1'b0;
            cnt   <= CNT_W'(RD_LOW_CYCLES - 1);
          end
        end
        ST_RD_LOW: begin
          if (cnt == '0) begin
            state <= ST_RD_HIGH;
            rd_n  <= 1'b1;
            cnt   <= CNT_W'(RD_HIGH_CYCLES - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RD_HIGH: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          rd_n  <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

  // data_in is sampled on the edge that ends the last low cycle, while rd_n
  // is still low at the device.
  assign push       = (state == ST_RD_LOW) && (cnt == '0);
  assign pop        = m_valid && m_ready;
  assign receive_on = (state != ST_IDLE);

  ft245_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (D_WIDTH)
  ) u_fifo (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .push       (push),
    .push_data  (data_in),
    .pop        (pop),
    .head_data  (m_data),
    .head_valid (m_valid),
    .level      (fifo_level)
  );

`ifdef FT245_RX_BYTE_COUNT_EN
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      rx_count <= '0;
    end else if (push) begin
      rx_count <= rx_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ft245_fifo_read.md
Name: ft245_fifo_read

Overview:
Receive-side counterpart of the FT245 FIFO write path. Reads bytes from the FT245 asynchronous FIFO interface by strobing rd_n while rxf_n indicates data is available. Buffers each byte in a small internal FIFO and presents it downstream on a valid/ready stream. Sits between the FT245 pins and the host-command / loopback logic in the same clock_in domain as the write path.

Parameters:
DEPTH, 16, internal FIFO entries; power of 2, minimum 2
RD_LOW_CYCLES, 3, clock_in cycles rd_n is held low per byte; data sampled on the last of them; minimum 1
RD_HIGH_CYCLES, 4, clock_in cycles rd_n is held high after each strobe before rxf_n is re-evaluated; minimum 3, which covers the synchronizer latency

Ports:
clock_in  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous, active-low reset
rxf_n  in  1  FT245 receive-FIFO-empty flag, asynchronous; low = byte available
data_in  in  8  FT245 data bus; read direction only
rd_n  out  1  FT245 read strobe, active low, registered
enable  in  1  permits new read strobes
m_data  out  8  head-of-FIFO byte
m_valid  out  1  m_data holds a valid byte
m_ready  in  1  downstream accepts; a pop occurs when m_valid && m_ready
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
receive_on  out  1  high during RD_LOW and RD_HIGH

Behaviour:
- Reset, asynchronous assert: rd_n=1, state=IDLE, FIFO empty, m_valid=0, m_data=0, fifo_level=0, receive_on=0, synchronizer flops=1. Release is synchronous to posedge.
- rxf_n passes through a 2-flop synchronizer, reset value 1, producing rxf_s. data_in is not synchronized; it is stable while rd_n is low.
- State IDLE: when enable && !rxf_s && fifo_level<DEPTH, go to RD_LOW on the next edge. rd_n goes to 0 and the counter loads RD_LOW_CYCLES-1.
- State RD_LOW: rd_n=0. Decrement the counter each cycle.
  - When the counter reaches 0, push data_in into the FIFO on that edge.
  - On the same edge, rd_n goes to 1, the counter loads RD_HIGH_CYCLES-1, and the state moves to RD_HIGH.
- State RD_HIGH: rd_n=1. When the counter reaches 0, return to IDLE.
- Throughput: one byte per RD_LOW_CYCLES+RD_HIGH_CYCLES+1 cycles. With defaults that is 8 cycles per byte.
- First rd_n fall occurs 3 cycles after rxf_n falls: 2 for the synchronizer and 1 for the registered strobe.
- An issued strobe is never aborted:
  - Dropping enable mid-strobe completes the RD_LOW/RD_HIGH sequence and pushes the byte.
  - rxf_n rising mid-strobe is ignored until IDLE.
- Space is checked only at strobe start. Pops during the strobe only add room, so a push never hits a full FIFO. There is no overflow path.
- FIFO is first-word fall-through:
  - m_data shows the head entry whenever m_valid=1.
  - m_valid = (fifo_level!=0).
  - A byte pushed at edge N is visible at m_data/m_valid after edge N.
- Simultaneous push and pop: fifo_level unchanged and ordering preserved. Pop on empty is impossible because m_valid=0.
- Pointers wrap modulo DEPTH. fifo_level saturates structurally at DEPTH.
- Reset mid-strobe: rd_n returns to 1 immediately and the in-flight byte is lost. The FT245 is unaffected apart from a shortened strobe.

Optional Feature:
Macro FT245_RX_BYTE_COUNT_EN.
- Defined: adds output port rx_count (32 bits). Reset 0. Increments by 1 on every FIFO push and wraps at 2^32.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package ft245_pkg:
  - state encoding ST_IDLE=2'b00, ST_RD_LOW=2'b01, ST_RD_HIGH=2'b10
  - D_WIDTH=8
  - default timing constants, shared with the write path
- One sub-module, ft245_rx_fifo: synchronous FWFT FIFO with DEPTH and width parameters, push/pop, level output and asynchronous active-low reset.
- The strobe FSM, synchronizer and optional counter live in the top module.

Test Plan:
- Single byte:
  - Stimulus: enable=1, m_ready=0, rxf_n falls with data_in=8'hA5 held.
  - Required: rd_n low at cycles 3..5 after the rxf_n fall; m_valid=1 and m_data=8'hA5 at cycle 6; fifo_level=1.
- Burst:
  - Stimulus: rxf_n held low with a bus model presenting 8'h01..8'h10, m_ready=1.
  - Required: 16 bytes delivered in order at a spacing of 8 cycles; fifo_level never exceeds 1.
- Backpressure/full:
  - Stimulus: m_ready=0, rxf_n held low, DEPTH=16.
  - Required: exactly 16 strobes, then rd_n stays 1 and fifo_level=16.
  - Then raise m_ready for one cycle: exactly one more strobe follows.
- Enable drop mid-strobe:
  - Stimulus: deassert enable in the second RD_LOW cycle.
  - Required: rd_n low for the full 3 cycles, byte pushed, no further strobes.
- Reset mid-strobe:
  - Stimulus: assert reset_n=0 during RD_LOW.
  - Required: rd_n=1 within the same cycle (asynchronous); m_valid=0, fifo_level=0 after release.
  - With FT245_RX_BYTE_COUNT_EN defined: rx_count=0 after reset and equals the number of bytes pushed after 5 pushes.
